// File: rtl/regfile_sb.sv
// Parametrised register file: one write port, NUM_RD registered read ports,
// optional hardwired-zero entry 0, optional write bypass, and a per-entry busy scoreboard.
module regfile_sb #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_RD-1:0]          rd_en,
  input  logic [NUM_RD*ADDR_W-1:0]   rd_addr,
  output logic [NUM_RD*DATA_W-1:0]   rd_data,
  output logic [NUM_RD-1:0]          rd_busy,
  input  logic                       wr_en,
  input  logic [ADDR_W-1:0]          wr_addr,
  input  logic [DATA_W-1:0]          wr_data,
  input  logic                       rsv_en,
  input  logic [ADDR_W-1:0]          rsv_addr,
  input  logic                       flush,
  output logic                       rsv_err,
  output logic [(2**ADDR_W)-1:0]     busy_vec
);

  localparam int DEPTH = 2 ** ADDR_W;

  generate
    if (NUM_RD < 1 || NUM_RD > 4) begin : g_bad_num_rd
      $error("regfile_sb: NUM_RD must be in 1..4");
    end
  endgenerate

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DEPTH-1:0]  busy_reg;
  logic [DEPTH-1:0]  busy_next;
  logic              rsv_err_reg;
  logic              rsv_err_next;
  logic              wr_ok;
  logic              rsv_hard_zero;

  assign wr_ok         = wr_en && !((ZERO_REG != 0) && (wr_addr == '0));
  assign rsv_hard_zero = (ZERO_REG != 0) && (rsv_addr == '0);

  // Reservation beats a completing write: the new in-flight producer is younger.
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_busy
      localparam bit HARD_ZERO = (ZERO_REG != 0) && (gi == 0);
      assign busy_next[gi] =
        HARD_ZERO                                  ? 1'b0 :
        flush                                      ? 1'b0 :
        (rsv_en && (rsv_addr == ADDR_W'(gi)))      ? 1'b1 :
        (wr_en  && (wr_addr  == ADDR_W'(gi)))      ? 1'b0 :
                                                     busy_reg[gi];
    end
  endgenerate

  assign rsv_err_next = rsv_en && busy_reg[rsv_addr] &&
                        !(wr_en && (wr_addr == rsv_addr)) &&
                        !flush && !rsv_hard_zero;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
      busy_reg    <= '0;
      rsv_err_reg <= 1'b0;
    end else begin
      if (wr_ok) begin
        mem_reg[wr_addr] <= wr_data;
      end
      busy_reg    <= busy_next;
      rsv_err_reg <= rsv_err_next;
    end
  end

  assign busy_vec = busy_reg;
  assign rsv_err  = rsv_err_reg;

  generate
    for (gi = 0; gi < NUM_RD; gi++) begin : g_rd
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] data_next;
      logic [DATA_W-1:0] data_reg;
      logic              busy_bit_next;
      logic              busy_bit_reg;

      assign addr = rd_addr[gi*ADDR_W +: ADDR_W];

      // Busy is reported post-update so issue sees this cycle's rsv/wr/flush.
      always_comb begin
        data_next     = mem_reg[addr];
        busy_bit_next = busy_next[addr];
        if ((ZERO_REG != 0) && (addr == '0)) begin
          data_next     = '0;
          busy_bit_next = 1'b0;
        end else if ((BYPASS != 0) && wr_en && (wr_addr == addr)) begin
          data_next = wr_data;
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          data_reg     <= '0;
          busy_bit_reg <= 1'b0;
        end else if (rd_en[gi]) begin
          data_reg     <= data_next;
          busy_bit_reg <= busy_bit_next;
        end
      end

      assign rd_data[gi*DATA_W +: DATA_W] = data_reg;
      assign rd_busy[gi]                  = busy_bit_reg;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_sb.sv
// Directed bench for regfile_sb: default config plus a ZERO_REG=0/BYPASS=0 copy on the same stimulus.
module tb_regfile_sb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  rd_en;
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        rsv_en;
  logic [4:0]  rsv_addr;
  logic        flush;

  logic [63:0] m_rd_data, a_rd_data;
  logic [1:0]  m_rd_busy, a_rd_busy;
  logic        m_rsv_err, a_rsv_err;
  logic [31:0] m_busy_vec, a_busy_vec;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    bit          alt;
    int          port;
    logic [31:0] data;
    logic        busy;
  } exp_t;

  exp_t exp_q[$];

  always #5 clk = ~clk;

  regfile_sb u_dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(m_rd_data),
    .rd_busy(m_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .rsv_err(m_rsv_err),
    .busy_vec(m_busy_vec)
  );

  regfile_sb #(.ZERO_REG(0), .BYPASS(0)) u_alt (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(a_rd_data),
    .rd_busy(a_rd_busy), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rsv_en(rsv_en), .rsv_addr(rsv_addr), .flush(flush), .rsv_err(a_rsv_err),
    .busy_vec(a_busy_vec)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Queue one read on both instances with their respective expected results.
  task automatic rd(input int port, input logic [4:0] addr, input string tag,
                    input logic [31:0] dm, input logic bm,
                    input logic [31:0] da, input logic ba);
    rd_en[port]          = 1'b1;
    rd_addr[port*5 +: 5] = addr;
    exp_q.push_back('{tag: {tag, "_m"}, alt: 1'b0, port: port, data: dm, busy: bm});
    exp_q.push_back('{tag: {tag, "_a"}, alt: 1'b1, port: port, data: da, busy: ba});
  endtask

  task automatic cycle();
    exp_t        e;
    logic [31:0] od;
    logic        ob;
    @(posedge clk);
    #1;
    while (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      od = e.alt ? a_rd_data[e.port*32 +: 32] : m_rd_data[e.port*32 +: 32];
      ob = e.alt ? a_rd_busy[e.port] : m_rd_busy[e.port];
      chk({e.tag, "_data"}, {32'h0, od}, {32'h0, e.data});
      chk({e.tag, "_busy"}, {63'h0, ob}, {63'h0, e.busy});
    end
    wr_en  = 1'b0;
    rsv_en = 1'b0;
    flush  = 1'b0;
    rd_en  = '0;
  endtask

  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
  endtask

  task automatic rsv(input logic [4:0] a);
    rsv_en   = 1'b1;
    rsv_addr = a;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rd_en = '0; rd_addr = '0; wr_en = 1'b0; wr_addr = '0;
    wr_data = '0; rsv_en = 1'b0; rsv_addr = '0; flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_busy_vec", {32'h0, m_busy_vec}, 64'h0);
    chk("rst_rd_data", m_rd_data, 64'h0);
    chk("rst_rd_busy", {62'h0, m_rd_busy}, 64'h0);
    chk("rst_rsv_err", {63'h0, m_rsv_err}, 64'h0);
    rst_n = 1'b1;

    // write then read on both ports, latency 1
    wr(5'd7, 32'hDEADBEEF); cycle();
    rd(0, 5'd7, "lat_p0", 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
    rd(1, 5'd7, "lat_p1", 32'hDEADBEEF, 1'b0, 32'hDEADBEEF, 1'b0);
    cycle();

    // bypass vs. pre-write value
    wr(5'd3, 32'h11); cycle();
    wr(5'd3, 32'h22);
    rd(0, 5'd3, "byp", 32'h22, 1'b0, 32'h11, 1'b0);
    cycle();
    rd(0, 5'd3, "byp_next", 32'h22, 1'b0, 32'h22, 1'b0);
    cycle();

    // hardwired zero entry
    wr(5'd0, 32'hFFFFFFFF); rsv(5'd0); cycle();
    chk("zero_busy_m", {63'h0, m_busy_vec[0]}, 64'h0);
    chk("zero_busy_a", {63'h0, a_busy_vec[0]}, 64'h1);
    chk("zero_err_m", {63'h0, m_rsv_err}, 64'h0);
    rd(0, 5'd0, "zero_rd", 32'h0, 1'b0, 32'hFFFFFFFF, 1'b1);
    cycle();
    flush = 1'b1; cycle();
    chk("flush_alt", {32'h0, a_busy_vec}, 64'h0);

    // scoreboard on r5
    rsv(5'd5);
    rd(1, 5'd5, "rsv_rd", 32'h0, 1'b1, 32'h0, 1'b1);
    cycle();
    chk("rsv5_busy", {63'h0, m_busy_vec[5]}, 64'h1);
    chk("rsv5_err0", {63'h0, m_rsv_err}, 64'h0);
    rsv(5'd5); cycle();
    chk("rsv5_err1", {63'h0, m_rsv_err}, 64'h1);
    cycle();
    chk("rsv5_err_pulse", {63'h0, m_rsv_err}, 64'h0);
    chk("rsv5_still_busy", {63'h0, m_busy_vec[5]}, 64'h1);
    wr(5'd5, 32'h55); rsv(5'd5); cycle();
    chk("wr_rsv_err", {63'h0, m_rsv_err}, 64'h0);
    chk("wr_rsv_busy", {63'h0, m_busy_vec[5]}, 64'h1);
    wr(5'd5, 32'h77);
    rd(1, 5'd5, "wr_clear", 32'h77, 1'b0, 32'h55, 1'b0);
    cycle();
    chk("wr_clear_vec", {32'h0, m_busy_vec}, 64'h0);

    // flush priority
    rsv(5'd2); cycle();
    rsv(5'd9); cycle();
    chk("busy_2_9", {32'h0, m_busy_vec}, 64'h204);
    flush = 1'b1; rsv(5'd4); wr(5'd10, 32'h5); cycle();
    chk("flush_vec", {32'h0, m_busy_vec}, 64'h0);
    chk("flush_err", {63'h0, m_rsv_err}, 64'h0);
    rd(0, 5'd10, "flush_wr", 32'h5, 1'b0, 32'h5, 1'b0);
    cycle();
    rsv(5'd2); cycle();
    flush = 1'b1; rsv(5'd2); cycle();
    chk("flush_rsv_err", {63'h0, m_rsv_err}, 64'h0);
    chk("flush_rsv_vec", {32'h0, m_busy_vec}, 64'h0);

    // disabled ports hold their outputs
    rd_addr = {5'd3, 5'd7}; cycle();
    chk("hold_p0", {32'h0, m_rd_data[31:0]}, 64'h5);
    chk("hold_p1", {32'h0, m_rd_data[63:32]}, 64'h77);

    // async reset with busy entries and a pending rsv_err
    rsv(5'd4); cycle();
    rsv(5'd5); cycle();
    rsv(5'd6); cycle();
    rsv(5'd7); cycle();
    rsv(5'd7); cycle();
    chk("pre_rst_vec", {32'h0, m_busy_vec}, 64'hF0);
    chk("pre_rst_err", {63'h0, m_rsv_err}, 64'h1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_vec", {32'h0, m_busy_vec}, 64'h0);
    chk("async_rd", m_rd_data, 64'h0);
    chk("async_err", {63'h0, m_rsv_err}, 64'h0);
    chk("async_rd_alt", a_rd_data, 64'h0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle();
    chk("post_rst_hold", m_rd_data, 64'h0);
    rd(0, 5'd7, "post_rst_r7", 32'h0, 1'b0, 32'h0, 1'b0);
    rd(1, 5'd10, "post_rst_r10", 32'h0, 1'b0, 32'h0, 1'b0);
    cycle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
